// File: rtl/iterative_alu_unit.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/compare ops and iterative shifts
// (one bit per cycle), with valid/ready handshakes on command and result.
module iterative_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             branch_taken,
    output logic             illegal_op
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLL  = 4'h2;
    localparam logic [3:0] OP_SLT  = 4'h3;
    localparam logic [3:0] OP_SLTU = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SRA  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_EQ   = 4'hA;
    localparam logic [3:0] OP_NE   = 4'hB;
    localparam logic [3:0] OP_GE   = 4'hC;
    localparam logic [3:0] OP_GEU  = 4'hD;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRA) || (op == OP_SRL);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] exec_result;
    logic [WIDTH-1:0] shift_next;
    logic             exec_cond;
    logic             exec_is_cmp;
    logic             exec_illegal;

    // Final-cycle evaluation; a_q already holds the fully shifted value for shift ops.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        exec_result  = '0;
        exec_cond    = 1'b0;
        exec_is_cmp  = 1'b0;
        exec_illegal = 1'b0;
        case (op_q)
            OP_ADD:                exec_result = a_q + b_q;
            OP_SUB:                exec_result = a_q - b_q;
            OP_SLL, OP_SRA, OP_SRL: exec_result = a_q;
            OP_XOR:                exec_result = a_q ^ b_q;
            OP_OR:                 exec_result = a_q | b_q;
            OP_AND:                exec_result = a_q & b_q;
            OP_SLT:  begin exec_is_cmp = 1'b1; exec_cond = $signed(a_q) <  $signed(b_q); end
            OP_SLTU: begin exec_is_cmp = 1'b1; exec_cond = a_q <  b_q; end
            OP_EQ:   begin exec_is_cmp = 1'b1; exec_cond = a_q == b_q; end
            OP_NE:   begin exec_is_cmp = 1'b1; exec_cond = a_q != b_q; end
            OP_GE:   begin exec_is_cmp = 1'b1; exec_cond = $signed(a_q) >= $signed(b_q); end
            OP_GEU:  begin exec_is_cmp = 1'b1; exec_cond = a_q >= b_q; end
            default:               exec_illegal = 1'b1;
        endcase
        if (exec_is_cmp) begin
            exec_result = {{(WIDTH-1){1'b0}}, exec_cond};
        end
    end

    always_comb begin
        case (op_q)
            OP_SLL:  shift_next = {a_q[WIDTH-2:0], 1'b0};
            OP_SRA:  shift_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            default: shift_next = {1'b0, a_q[WIDTH-1:1]};
        endcase
    end

    // SHIFT doubles as the execute state: non-shift ops enter it with a zero count.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = operand_a;
                    b_d     = operand_b;
                    op_d    = alu_control;
                    cnt_d   = is_shift(alu_control) ? operand_b[SHW-1:0] : '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    a_d   = shift_next;
                    cnt_d = cnt_q - SHW'(1);
                end else begin
                    result_d  = exec_result;
                    taken_d   = exec_cond;
                    illegal_d = exec_illegal;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: datapath registers are reset too, so outputs read as zero after reset.
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign result       = result_q;
    assign branch_taken = taken_q;
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_iterative_alu_unit.sv
// Self-checking bench for iterative_alu_unit: directed test-plan scenarios plus
// randomized ops checked against a behavioural reference model.
module tb_iterative_alu_unit;

    localparam int WIDTH = 32;
    localparam int TIMEOUT = 100;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             branch_taken;
    logic             illegal_op;

    int tests_run    = 0;
    int tests_failed = 0;

    iterative_alu_unit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_control  (alu_control),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal_op   (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: whole-word shifts and plain compares.
    function automatic void ref_model(input logic [3:0] code, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic t, output logic il, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = '0;
        t   = 1'b0;
        il  = 1'b0;
        lat = 1;
        case (code)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: begin r = a << sh; lat = 1 + sh; end
            4'h3: t = $signed(a) < $signed(b);
            4'h4: t = a < b;
            4'h5: r = a ^ b;
            4'h6: begin r = 32'($signed(a) >>> sh); lat = 1 + sh; end
            4'h7: begin r = a >> sh; lat = 1 + sh; end
            4'h8: r = a | b;
            4'h9: r = a & b;
            4'hA: t = (a == b);
            4'hB: t = (a != b);
            4'hC: t = $signed(a) >= $signed(b);
            4'hD: t = a >= b;
            default: il = 1'b1;
        endcase
        if (code == 4'h3 || code == 4'h4 || (code >= 4'hA && code <= 4'hD))
            r = t ? 32'd1 : 32'd0;
    endfunction

    // Present one command at a negedge; returns #1 after the accept edge with
    // the command inputs scrambled so late changes would be noticed.
    task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
        end
        in_valid    = 1'b1;
        alu_control = code;
        operand_a   = a;
        operand_b   = b;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        operand_a   = $urandom;
        operand_b   = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_valid: no out_valid within %0d cycles", TIMEOUT);
        end
    endtask

    // Full transaction with out_ready high; checks outputs, latency and release.
    task automatic do_op(input string name, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input logic exp_t,
                         input logic exp_il, input int exp_lat);
        int lat;
        out_ready = 1'b1;
        issue(code, a, b);
        wait_valid(lat);
        tests_run++;
        if (result !== exp_r || branch_taken !== exp_t || illegal_op !== exp_il) begin
            tests_failed++;
            $display("FAIL %s: code=%h a=%h b=%h got r=%h t=%b il=%b required r=%h t=%b il=%b",
                     name, code, a, b, result, branch_taken, illegal_op, exp_r, exp_t, exp_il);
        end
        tests_run++;
        if (lat != exp_lat) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b required 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_control = '0;
        operand_a   = '0;
        operand_b   = '0;
        #3;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 ||
            branch_taken !== 1'b0 || illegal_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: ov=%b ir=%b r=%h t=%b il=%b required 0 1 0 0 0",
                     out_valid, in_ready, result, branch_taken, illegal_op);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_add_sub;
        do_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0, 1'b0, 1);
        do_op("sub_wrap", 4'h1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    endtask

    task automatic test_compare;
        do_op("slt",  4'h3, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b0, 1);
        do_op("sltu", 4'h4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
        do_op("ge",   4'hC, 32'd5, 32'd5, 32'd1, 1'b1, 1'b0, 1);
        do_op("ne",   4'hB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1);
    endtask

    task automatic test_shift;
        do_op("sra4",   4'h6, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 5);
        do_op("srl4",   4'h7, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 5);
        do_op("sll31",  4'h2, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
        do_op("shamt0", 4'h7, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 1);
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        out_ready = 1'b0;
        issue(4'h9, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_valid(lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            alu_control = 4'h0;
            operand_a   = $urandom;
            operand_b   = $urandom;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'hF000_F000 ||
                illegal_op !== 1'b0)
                bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL backpressure_hold: %0d bad cycles required 0 (last r=%h ov=%b ir=%b)",
                     bad, result, out_valid, in_ready);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: ov=%b ir=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_illegal;
        do_op("illegal_f", 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1);
        do_op("illegal_e", 4'hE, 32'h5, 32'h5, 32'd0, 1'b0, 1'b1, 1);
        do_op("after_illegal", 4'h5, 32'hFF00_00FF, 32'h0F0F_0F0F, 32'hF00F_0FF0, 1'b0, 1'b0, 1);
    endtask

    task automatic test_reset_mid_shift;
        int seen;
        issue(4'h7, 32'hFFFF_0000, 32'd20);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_shift: ov=%b ir=%b r=%h required 0 1 0",
                     out_valid, in_ready, result);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL stale_result: out_valid high %0d cycles required 0", seen);
        end
        do_op("add_after_reset", 4'h0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);
    endtask

    task automatic test_random;
        logic [3:0]  code;
        logic [31:0] a, b, r;
        logic        t, il;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            code = 4'($urandom_range(0, 15));
            a    = $urandom;
            b    = $urandom;
            if (i % 3 == 0) a = a | 32'h8000_0000;
            if (i % 5 == 0) b = a;
            ref_model(code, a, b, r, t, il, lat);
            do_op("random", code, a, b, r, t, il, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_compare();
        test_shift();
        test_backpressure();
        test_illegal();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/iterative_alu_unit.md
Name: iterative_alu_unit

Overview:
- Execution-side counterpart of the ALU control decoder: consumes the 4-bit aluControl code plus two operands and produces a result and a branch-condition flag.
- Intended for the multi-cycle core variant. Shifts run iteratively, one bit position per cycle, instead of through a barrel shifter.
- Valid/ready handshakes on both the command side and the result side.

Parameters:
- WIDTH, 32, operand/result width in bits; shift amount is operand_b[$clog2(WIDTH)-1:0].

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  command valid
- in_ready  output  1  unit can accept a command
- alu_control  input  4  operation code (see Behaviour)
- operand_a  input  WIDTH  first operand (rs1)
- operand_b  input  WIDTH  second operand (rs2 or immediate)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  ALU result
- branch_taken  output  1  branch/compare condition true
- illegal_op  output  1  alu_control was not a defined code

Behaviour:
- Codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRA, 7 SRL, 8 OR, 9 AND
  - A EQ, B NE, C GE (signed), D GEU
  - E, F illegal
- Compare codes 3, 4, A–D:
  - result = {WIDTH-1 zeros, cond}
  - branch_taken = cond
- All other codes: branch_taken = 0.
- Arithmetic wraps modulo 2^WIDTH. Carry and overflow are discarded.
- Reset (reset_n low, asynchronous):
  - state = IDLE, in_ready = 1 after reset.
  - out_valid = 0, result = 0, branch_taken = 0, illegal_op = 0, shift counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch operands and code.
  - Non-shift code → DONE next cycle, with result computed from the latched inputs.
  - Shift code (2/6/7) with shamt = 0 → DONE with result = operand_a.
  - Shift code with shamt > 0 → SHIFT; counter = shamt, working register = operand_a.
- SHIFT:
  - in_ready = 0.
  - Each cycle, shift the working register by 1: SLL fills with 0, SRL fills with 0, SRA replicates the MSB.
  - Decrement the counter. When the counter reaches 0 after a shift, go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - result, branch_taken and illegal_op are stable until the transfer.
  - On out_ready, go to IDLE; out_valid deasserts the next cycle.
- Latency from accept edge to out_valid high:
  - Non-shift: 1 cycle.
  - Shift: 1 + shamt cycles (max WIDTH for WIDTH=32 ⇒ 32 cycles).
- Throughput: at most one command per 2 cycles. A new command is not accepted in the same cycle a result is consumed.
- Illegal code: handled as a 1-cycle op with result = 0, branch_taken = 0, illegal_op = 1. illegal_op is 0 for all defined codes.
- Inputs are sampled only at the accept edge. Changes on alu_control or operands at any other time have no effect.
- in_valid while busy is ignored. No command queuing.
- out_ready held low in DONE: outputs hold indefinitely.
- reset_n asserted mid-shift or in DONE: the operation is abandoned, all outputs go to reset values immediately, and no result is produced after release.

Test Plan:
- ADD/SUB wrap: code 0, a=0xFFFF_FFFF, b=1 → result=0x0000_0000 one cycle after accept; code 1, a=0, b=1 → 0xFFFF_FFFF; branch_taken=0.
- Compares: code 3, a=0xFFFF_FFFF, b=1 → result=1, branch_taken=1; code 4 same operands → result=0, taken=0; code C, a=5, b=5 → taken=1; code B, a=5, b=5 → taken=0.
- Shifts and latency:
  - code 6, a=0x8000_0000, b=4 → result=0xF800_0000, out_valid exactly 5 cycles after accept.
  - code 7, same operands → 0x0800_0000.
  - code 2, a=1, b=31 → 0x8000_0000 after 32 cycles.
  - b=0x20 (shamt 0) → result=a after 1 cycle.
- Backpressure: complete code 9, a=0xF0F0_F0F0, b=0xFF00_FF00; hold out_ready=0 for 10 cycles → result 0xF000_F000 stable, in_ready=0, extra in_valid ignored; raise out_ready → IDLE next cycle.
- Illegal code: code F, any operands → illegal_op=1, result=0, branch_taken=0 after 1 cycle; the following legal op clears illegal_op.
- Reset mid-shift: start code 7 with shamt=20; pull reset_n low at cycle 6 → out_valid=0, in_ready=1 after release, no stale result; the next ADD 2+3 returns 5.
